// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that latches one multi-byte message per grant and feeds it
// byte by byte into a uart_tx serialiser. Define UART_TX_ARB_CHECKSUM_EN to append an XOR checksum byte.
module uart_tx_arbiter #(
  parameter int NREQ      = 2,
  parameter int MSG_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*MSG_BYTES*8-1:0] msg_data,
  output logic [NREQ-1:0]             ack,
  output logic [NREQ-1:0]             done,
  output logic                        busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_din,
  input  logic                        tx_done_tick
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MSG_BYTES + 1);
  localparam int MW = MSG_BYTES * 8;
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int LAST = MSG_BYTES;
`else
  localparam int LAST = MSG_BYTES - 1;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t          state;
  logic [GW-1:0]   rr;
  logic [BW-1:0]   byte_idx;
  logic [MW-1:0]   msg_buf;

  logic            grant_found;
  logic [GW-1:0]   grant_idx;
  logic [GW-1:0]   cand;
  logic [MW-1:0]   sel_msg;
  logic [7:0]      next_byte;

`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [7:0]      csum_q;
  logic [7:0]      sel_csum;

  always_comb begin
    sel_csum = 8'h00;
    for (int b = 0; b < MSG_BYTES; b++) sel_csum ^= sel_msg[b*8 +: 8];
  end
`endif

  // Scan upward from the requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(rr) + k) % NREQ);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_msg   = MW'(msg_data >> (MW * int'(grant_idx)));
    next_byte = 8'(msg_buf >> (8 * (int'(byte_idx) + 1)));
`ifdef UART_TX_ARB_CHECKSUM_EN
    if (byte_idx == BW'(MSG_BYTES - 1)) next_byte = csum_q;
`endif
  end

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= GW'(NREQ - 1);
      byte_idx <= '0;
      // NOTE: the message buffer is small, so it is reset with the rest rather than left undefined.
      msg_buf  <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
      ack      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_din   <= 8'h00;
    end else begin
      ack      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            msg_buf  <= sel_msg;
`ifdef UART_TX_ARB_CHECKSUM_EN
            csum_q   <= sel_csum;
`endif
            rr       <= grant_idx;
            byte_idx <= '0;
            ack      <= NREQ'(1) << grant_idx;
            busy     <= 1'b1;
            tx_start <= 1'b1;
            tx_din   <= sel_msg[7:0];
            state    <= SEND;
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (tx_done_tick) begin
            if (byte_idx == BW'(LAST)) begin
              done  <= NREQ'(1) << rr;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              tx_din   <= next_byte;
              tx_start <= 1'b1;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
